// File: rtl/raw_readout_pkg.sv
// Shared constants and FSM state encoding for the raw hit memory readout.
package raw_readout_pkg;
  localparam int AW  = 8;
  localparam int DW  = 288;
  localparam int OW  = 16;
  localparam int NW  = DW / OW;
  localparam int WCW = $clog2(NW);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/raw_frame_slicer.sv
// Holds one memory frame and presents it a word at a time, LSB word first.
module raw_frame_slicer
  import raw_readout_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           adv,
  input  logic [DW-1:0]  din,
  output logic [OW-1:0]  word,
  output logic [WCW-1:0] wcnt,
  output logic           last
);
  logic [DW-1:0] frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame <= '0;
      wcnt  <= '0;
    end else if (load) begin
      frame <= din;
      wcnt  <= '0;
    end else if (adv) begin
      wcnt  <= wcnt + WCW'(1);
    end
  end

  assign word = frame[int'(wcnt)*OW +: OW];
  assign last = (wcnt == WCW'(NW - 1));
endmodule

// File: rtl/raw_readout.sv
// Drains whole blocks of frames from the raw hit memory and streams them as
// 16-bit words; advancing adb releases the drained block back to the writer.
module raw_readout
  import raw_readout_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] adw,
  input  logic [AW-1:0] wblock,
  input  logic [DW-1:0] dr,
  output logic [AW-1:0] adr,
  output logic [AW-1:0] adb,
  output logic [OW-1:0] dout,
  output logic          dvalid,
  input  logic          dready,
  output logic          dfirst,
  output logic          dlast,
  output logic          busy
);
  state_t         state, state_nxt;
  logic [AW-1:0]  wb_l, fcnt, avail;
  logic           start, load, adv, next_frame, hs, last_word, last_frame;
  logic [WCW-1:0] wcnt;

  // mod-2^AW difference, so a wrapped writer still yields the right fill level
  assign avail      = adw - adb;
  assign hs         = dvalid & dready;
  assign last_frame = (fcnt == wb_l - AW'(1));

  raw_frame_slicer u_slicer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .adv   (adv),
    .din   (dr),
    .word  (dout),
    .wcnt  (wcnt),
    .last  (last_word)
  );

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    load       = 1'b0;
    adv        = 1'b0;
    next_frame = 1'b0;
    case (state)
      IDLE: if (wblock != '0 && avail >= wblock) begin
        start     = 1'b1;
        state_nxt = ADDR;
      end
      ADDR: state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (hs) begin
        if (!last_word)      adv = 1'b1;
        else if (!last_frame) begin
          next_frame = 1'b1;
          state_nxt  = ADDR;
        end else             state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      dvalid <= 1'b0;
      adr    <= '0;
      adb    <= '0;
      wb_l   <= '0;
      fcnt   <= '0;
    end else begin
      state  <= state_nxt;
      dvalid <= (state_nxt == SHIFT);
      if (start) begin
        wb_l <= wblock;
        adr  <= adb;
        fcnt <= '0;
      end
      if (next_frame) begin
        adr  <= adr + AW'(1);
        fcnt <= fcnt + AW'(1);
      end
      if (state == DONE) adb <= adb + wb_l;
    end
  end

  // Derived from registers only, so they hold while the sink stalls
  assign dfirst = dvalid && (fcnt == '0) && (wcnt == '0);
  assign dlast  = dvalid && last_frame && last_word;
  assign busy   = (state != IDLE);
endmodule
